// File: rtl/secure_test_pkg.sv
// Shared types and constants for the secure test-port gate: attack codes,
// gate state encoding, default LFSR seed/polynomial and the Galois step.
package secure_test_pkg;

  localparam logic [31:0] DEFAULT_LFSR_SEED = 32'hACE1_2025;
  localparam logic [31:0] DEFAULT_LFSR_POLY = 32'h8020_0003;

  typedef enum logic [3:0] {
    ATTACK_NONE   = 4'd0,
    ATTACK_MITM   = 4'd1,
    ATTACK_TAMPER = 4'd2
  } attack_e;

  typedef enum logic [1:0] {
    GATE_PASS   = 2'd0,
    GATE_DUMMY  = 2'd1,
    GATE_LOCKED = 2'd2
  } gate_state_e;

  // Right-shifting Galois step: shifted-out bit folds the mask back in.
  function automatic logic [31:0] galois_step(input logic [31:0] s,
                                              input logic [31:0] poly);
    return s[0] ? ((s >> 1) ^ poly) : (s >> 1);
  endfunction

endpackage

// File: rtl/pattern_lfsr.sv
// 32-bit Galois LFSR producing dummy scan beats; advances only when asked.
// An all-zero seed would lock the register at zero, so it is replaced by 1.
module pattern_lfsr
  import secure_test_pkg::*;
#(
  parameter logic [31:0] LFSR_SEED = DEFAULT_LFSR_SEED,
  parameter logic [31:0] LFSR_POLY = DEFAULT_LFSR_POLY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  output logic [31:0] value
);

  localparam logic [31:0] SEED_EFF = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (advance) begin
      lfsr_d = galois_step(lfsr_q, LFSR_POLY);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= SEED_EFF;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/secure_pattern_gate.sv
// Registered stream gate: forwards real beats, substitutes LFSR dummies, or
// locks the port until reset. Optional event log: SECURE_PATTERN_GATE_EVENT_LOG_EN.
module secure_pattern_gate
  import secure_test_pkg::*;
#(
  parameter logic [31:0] LFSR_SEED = DEFAULT_LFSR_SEED,
  parameter logic [31:0] LFSR_POLY = DEFAULT_LFSR_POLY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        send_dummy_patterns,
  input  logic        stop_test,
  input  logic        tamper_flag,
  input  logic [3:0]  attack_type,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        locked,
  output logic [3:0]  locked_attack,
  output logic [7:0]  dummy_count,
  output logic [7:0]  event_count,
  output logic [3:0]  last_attack
);

  gate_state_e state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_is_dummy_q, out_is_dummy_d;
  logic        locked_q, locked_d;
  logic [3:0]  locked_attack_q, locked_attack_d;
  logic [7:0]  dummy_count_q, dummy_count_d;

  logic        slot_free;
  logic        dummy_load;
  logic [31:0] lfsr_value;

  pattern_lfsr #(
    .LFSR_SEED (LFSR_SEED),
    .LFSR_POLY (LFSR_POLY)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (dummy_load),
    .value   (lfsr_value)
  );

  always_comb begin
    slot_free  = !out_valid_q || out_ready;
    in_ready   = (state_q == GATE_PASS) && slot_free;
    dummy_load = (state_q == GATE_DUMMY) && slot_free && !stop_test;

    state_d         = state_q;
    out_valid_d     = out_valid_q;
    out_data_d      = out_data_q;
    out_is_dummy_d  = out_is_dummy_q;
    locked_d        = locked_q;
    locked_attack_d = locked_attack_q;
    dummy_count_d   = dummy_count_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      if (out_is_dummy_q && dummy_count_q != 8'hFF) begin
        dummy_count_d = dummy_count_q + 8'd1;
      end
    end

    case (state_q)
      GATE_PASS: begin
        if (in_valid && in_ready) begin
          out_valid_d    = 1'b1;
          out_data_d     = in_data;
          out_is_dummy_d = 1'b0;
        end
        if (send_dummy_patterns) begin
          state_d = GATE_DUMMY;
        end
      end
      GATE_DUMMY: begin
        if (dummy_load) begin
          out_valid_d    = 1'b1;
          out_data_d     = lfsr_value;
          out_is_dummy_d = 1'b1;
        end
        if (!send_dummy_patterns) begin
          state_d = GATE_PASS;
        end
      end
      default: begin
        state_d = GATE_LOCKED;
      end
    endcase

    // Lockout wins over everything and deliberately drops any pending beat.
    if (state_q != GATE_LOCKED && stop_test) begin
      state_d         = GATE_LOCKED;
      out_valid_d     = 1'b0;
      out_data_d      = 32'h0;
      out_is_dummy_d  = 1'b0;
      locked_d        = 1'b1;
      locked_attack_d = attack_type;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= GATE_PASS;
      out_valid_q     <= 1'b0;
      out_data_q      <= 32'h0;
      out_is_dummy_q  <= 1'b0;
      locked_q        <= 1'b0;
      locked_attack_q <= 4'h0;
      dummy_count_q   <= 8'h0;
    end else begin
      state_q         <= state_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      out_is_dummy_q  <= out_is_dummy_d;
      locked_q        <= locked_d;
      locked_attack_q <= locked_attack_d;
      dummy_count_q   <= dummy_count_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign locked        = locked_q;
  assign locked_attack = locked_attack_q;
  assign dummy_count   = dummy_count_q;

`ifdef SECURE_PATTERN_GATE_EVENT_LOG_EN
  logic       tamper_prev_q, tamper_prev_d;
  logic [7:0] event_count_q, event_count_d;
  logic [3:0] last_attack_q, last_attack_d;

  always_comb begin
    tamper_prev_d = tamper_flag;
    event_count_d = event_count_q;
    last_attack_d = last_attack_q;
    if (tamper_flag && !tamper_prev_q && event_count_q != 8'hFF) begin
      event_count_d = event_count_q + 8'd1;
    end
    if (attack_type != 4'h0) begin
      last_attack_d = attack_type;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tamper_prev_q <= 1'b0;
      event_count_q <= 8'h0;
      last_attack_q <= 4'h0;
    end else begin
      tamper_prev_q <= tamper_prev_d;
      event_count_q <= event_count_d;
      last_attack_q <= last_attack_d;
    end
  end

  assign event_count = event_count_q;
  assign last_attack = last_attack_q;
`else
  logic unused_tamper_flag;
  assign unused_tamper_flag = tamper_flag;
  assign event_count = 8'h0;
  assign last_attack = 4'h0;
`endif

endmodule

// File: doc/secure_pattern_gate.md
# secure_pattern_gate

Registered stream gate between the tester-side scan pattern source and the chiplet test port, placed directly downstream of the tamper detection controller. In normal operation it forwards real test pattern beats through one register stage. While the controller asserts `send_dummy_patterns`, it replaces the stream with LFSR-generated dummy beats. On `stop_test` it locks the test port until reset, so a detected MITM or tamper attack never receives genuine patterns.

## Interface
Parameters:
- `LFSR_SEED`, 32'hACE1_2025: LFSR reset value. A zero value is replaced by 32'h1.
- `LFSR_POLY`, 32'h8020_0003: Galois feedback mask (x^32+x^22+x^2+x+1).

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `send_dummy_patterns` in 1: dummy phase request, a level from the tamper controller.
- `stop_test` in 1: one-cycle lockout pulse from the tamper controller.
- `tamper_flag` in 1: attack-detected level from the tamper controller.
- `attack_type` in 4: attack code (0 none, 1 MITM, 2 tamper); valid in the `stop_test` cycle.
- `in_valid`, `in_data[31:0]` in: real pattern stream from the tester.
- `in_ready` out 1: upstream accept.
- `out_valid`, `out_data[31:0]` out: stream to the chiplet test port.
- `out_ready` in 1: downstream accept.
- `locked` out 1: lockout active (sticky).
- `locked_attack` out 4: `attack_type` captured at lockout.
- `dummy_count` out 8: dummy beats delivered, saturating at 255.
- `event_count` out 8: rising edges of `tamper_flag`, saturating (event log).
- `last_attack` out 4: most recent nonzero `attack_type` seen (event log).

## Operation
- Reset values: state PASS, all outputs 0, LFSR = `LFSR_SEED`.
- Output stage: a single register holding `out_valid`/`out_data`.
  - The slot is free when `!out_valid || out_ready`.
  - A held beat is stable until accepted, except when the lockout flush clears it.
- State machine: PASS, DUMMY, LOCKED.
- PASS:
  - `in_ready` = slot free.
  - On `in_valid && in_ready`, the register loads `in_data`.
  - Next state: LOCKED if `stop_test`; else DUMMY if `send_dummy_patterns`; else stay.
- DUMMY:
  - `in_ready` = 0; no real beat is taken.
  - When the slot is free, the register loads the current LFSR value with `out_valid` = 1, and the LFSR advances one Galois step.
  - A real beat already in the register is delivered first; no dummy overwrites it.
  - `dummy_count` increments when a dummy beat handshakes.
  - Next state: LOCKED if `stop_test`; PASS when `send_dummy_patterns` = 0. Any dummy beat still pending completes normally in PASS.
- LOCKED:
  - Entry clears `out_valid` and `out_data`, discarding any pending beat. This is a deliberate break of the stream rule.
  - `in_ready` = 0, `locked` = 1, `locked_attack` = `attack_type` sampled in the `stop_test` cycle.
  - Exit only via `rst_n`.
- Priority when inputs coincide: `stop_test` over `send_dummy_patterns`.
- `stop_test` is ignored once LOCKED; `locked_attack` does not update.
- The LFSR is not reseeded between dummy episodes; only reset reseeds it.

## Timing
- PASS latency is 1 cycle: an input handshake in cycle N gives `out_valid` in cycle N+1. Full throughput when `out_ready` = 1.
- `send_dummy_patterns` high in cycle N:
  - state is DUMMY in N+1 and `in_ready` is 0 from N+1;
  - the first dummy `out_valid` is in N+2 at the earliest.
- `stop_test` high in cycle N: `locked` = 1 and `out_valid` = 0 in N+1.
- All ports read registered state; the only combinational path is `in_ready` (from `out_ready`).
- Reset taken mid-stream: everything returns to its reset value in the next cycle; the pending beat is lost.

## Configuration
- `SECURE_PATTERN_GATE_EVENT_LOG_EN` defined:
  - `event_count` counts 0→1 transitions of `tamper_flag`, using a one-flop edge detect and saturating at 255.
  - `last_attack` loads every cycle in which `attack_type` != 0.
- Undefined: `event_count` and `last_attack` are tied to 0 and their logic is removed. All other behaviour is identical.

## Structure
- Shared package `secure_test_pkg`:
  - attack codes ATTACK_NONE/MITM/TAMPER;
  - gate state enum;
  - default seed and polynomial constants.
- One sub-module `pattern_lfsr`:
  - 32-bit Galois LFSR with seed/poly parameters and an `advance` enable;
  - handles the zero-seed substitution.

## Test plan
- PASS streaming: 10 beats 0x1..0xA with `out_ready` = 1 → identical beats in order, 1-cycle latency, `dummy_count` = 0.
- Backpressure: `out_ready` low for 3 cycles mid-stream → `out_data` held stable, `in_ready` = 0, no beat lost or duplicated.
- Dummy phase: `send_dummy_patterns` high for 21 cycles with `out_ready` = 1 → first output 32'hACE1_2025, then successive Galois steps; `in_ready` = 0 throughout; `dummy_count` = number of handshakes (≤ 20).
- Lockout: `stop_test` pulse with `attack_type` = 2 while a beat is pending → next cycle `locked` = 1, `locked_attack` = 2, `out_valid` = 0; later `in_valid` is never accepted until `rst_n` is pulsed.
- Simultaneous: `stop_test` and `send_dummy_patterns` high together in PASS → LOCKED; no dummy beat emitted.
- Event log (macro on): three `tamper_flag` pulses with codes 1, 1, 2 → `event_count` = 3, `last_attack` = 2. With the macro off, both read 0.
